note_stream_sequencer: RTL

//  Play-mode scheduler that feeds the two-lane note LED display. Fetches 32-bit note words
//  for lane 1/lane 2 from the shared song ROM over one req/ack port, arbitrating lane 1

---
 rtl/note_stream_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/note_stream_sequencer.sv
// Play-mode note scheduler: fetches lane-1/lane-2 note words over one ROM port,
// steps a shared bit index on beat ticks and double-buffers the next word pair.
module note_stream_sequencer #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned SONG_LEN     = 64,
  parameter int unsigned PREFETCH_IDX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mode,
  input  logic              beat_tick,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [31:0]       rom_data,
  output logic [31:0]       next_note1,
  output logic [31:0]       next_note2,
  output logic [4:0]        next_idx1,
  output logic [4:0]        next_idx2,
  output logic              underrun,
  output logic              song_done
);
  localparam int unsigned     PTR_W     = ADDR_W - 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SONG_LEN - 1);
  localparam logic [4:0]      PF_IDX    = 5'(PREFETCH_IDX);
  localparam logic [2:0]      MODE_PLAY = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_L1, S_INIT_L2, S_RUN, S_PF_L1, S_PF_L2, S_DONE
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] word_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [31:0]      shadow1;
  logic [31:0]      shadow2;
  logic             shadow_valid;
  logic             abort;
  logic [4:0]       idx;
  logic             play;
  logic             fetching;
  logic             go_idle;
  logic             stepping;

  assign next_idx1 = idx;
  assign next_idx2 = idx;

  always_comb begin
    play     = (mode == MODE_PLAY);
    next_ptr = word_ptr + 1'b1;
    fetching = (state == S_INIT_L1) || (state == S_INIT_L2) ||
               (state == S_PF_L1)   || (state == S_PF_L2);
    // A fetch abandoned by leaving play mode only ends once the ROM acks it.
    go_idle  = (!play && (state == S_RUN || state == S_DONE)) ||
               (fetching && rom_ack && (abort || !play));
    stepping = play && !abort &&
               (state == S_RUN || state == S_PF_L1 || state == S_PF_L2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      word_ptr     <= '0;
      shadow1      <= '0;
      shadow2      <= '0;
      shadow_valid <= 1'b0;
      abort        <= 1'b0;
      idx          <= '0;
      rom_req      <= 1'b0;
      rom_addr     <= '0;
      next_note1   <= '0;
      next_note2   <= '0;
      underrun     <= 1'b0;
      song_done    <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (play) begin
            state    <= S_INIT_L1;
            word_ptr <= '0;
            rom_req  <= 1'b1;
            rom_addr <= '0;
            abort    <= 1'b0;
          end
        end
        S_INIT_L1: begin
          if (!play) abort <= 1'b1;
          if (rom_ack) begin
            next_note1 <= rom_data;
            state      <= S_INIT_L2;
            rom_addr   <= ADDR_W'(1);
          end
        end
        S_INIT_L2: begin
          if (!play) abort <= 1'b1;
          if (rom_ack) begin
            next_note2 <= rom_data;
            idx        <= '0;
            state      <= S_RUN;
            rom_req    <= 1'b0;
            rom_addr   <= '0;
          end
        end
        S_RUN: begin
          if (idx == PF_IDX && !shadow_valid && word_ptr < LAST_PTR) begin
            state    <= S_PF_L1;
            rom_req  <= 1'b1;
            rom_addr <= {next_ptr, 1'b0};
          end
        end
        S_PF_L1: begin
          if (!play) abort <= 1'b1;
          if (rom_ack) begin
            shadow1  <= rom_data;
            state    <= S_PF_L2;
            rom_addr <= {next_ptr, 1'b1};
          end
        end
        S_PF_L2: begin
          if (!play) abort <= 1'b1;
          if (rom_ack) begin
            shadow2      <= rom_data;
            shadow_valid <= 1'b1;
            state        <= S_RUN;
            rom_req      <= 1'b0;
            rom_addr     <= '0;
          end
        end
        S_DONE: ;
        default: state <= S_IDLE;
      endcase

      if (stepping && beat_tick) begin
        if (idx != 5'd31) begin
          idx <= idx + 1'b1;
        end else if (word_ptr == LAST_PTR) begin
          state      <= S_DONE;
          next_note1 <= '0;
          next_note2 <= '0;
          idx        <= '0;
          song_done  <= 1'b1;
          rom_req    <= 1'b0;
          rom_addr   <= '0;
        end else if (shadow_valid || (state == S_PF_L2 && rom_ack)) begin
          // The L2 word arriving on this very edge is forwarded past the shadow.
          next_note1   <= shadow1;
          next_note2   <= shadow_valid ? shadow2 : rom_data;
          word_ptr     <= next_ptr;
          shadow_valid <= 1'b0;
          idx          <= '0;
        end else begin
          underrun <= 1'b1;
        end
      end

      if (go_idle) begin
        state        <= S_IDLE;
        word_ptr     <= '0;
        shadow1      <= '0;
        shadow2      <= '0;
        shadow_valid <= 1'b0;
        abort        <= 1'b0;
        idx          <= '0;
        rom_req      <= 1'b0;
        rom_addr     <= '0;
        next_note1   <= '0;
        next_note2   <= '0;
        underrun     <= 1'b0;
        song_done    <= 1'b0;
      end
    end
  end
endmodule
